// File: rtl/operand_entry_sequencer_pkg.sv
// Shared types and defaults for the operand entry sequencer.
package operand_entry_sequencer_pkg;

    // Default widths: one switch bank is half an operand.
    localparam int SW_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    // Phase codes shown on the status LEDs; the state enum uses them directly.
    localparam logic [2:0] PHASE_A_HI  = 3'd0;
    localparam logic [2:0] PHASE_A_LO  = 3'd1;
    localparam logic [2:0] PHASE_B_HI  = 3'd2;
    localparam logic [2:0] PHASE_B_LO  = 3'd3;
    localparam logic [2:0] PHASE_ISSUE = 3'd4;

    typedef enum logic [2:0] {
        S_A_HI  = PHASE_A_HI,
        S_A_LO  = PHASE_A_LO,
        S_B_HI  = PHASE_B_HI,
        S_B_LO  = PHASE_B_LO,
        S_ISSUE = PHASE_ISSUE
    } state_e;

endpackage

// File: rtl/operand_entry_sequencer.sv
// Operand entry sequencer: assembles two 2*SW_W operands from four switch
// entries (A high, A low, B high, B low) and offers the pair to the FPMAC
// with a valid/ready handshake.  Counts accepted pairs.
module operand_entry_sequencer
    import operand_entry_sequencer_pkg::*;
#(
    parameter int SW_W  = SW_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_pulse,
    input  logic [SW_W-1:0]   switches,
    input  logic              clear,
    output logic [2*SW_W-1:0] op_a,
    output logic [2*SW_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        phase,
    output logic [CNT_W-1:0]  issued_cnt
);

    state_e            state_r;
    state_e            state_next_s;
    logic [2*SW_W-1:0] op_a_r;
    logic [2*SW_W-1:0] op_a_next_s;
    logic [2*SW_W-1:0] op_b_r;
    logic [2*SW_W-1:0] op_b_next_s;
    logic              out_valid_r;
    logic              out_valid_next_s;
    logic [CNT_W-1:0]  issued_cnt_r;
    logic [CNT_W-1:0]  issued_cnt_next_s;

    // Next-state and datapath updates; clear outranks entry and handshake.
    always_comb begin
        state_next_s      = state_r;
        op_a_next_s       = op_a_r;
        op_b_next_s       = op_b_r;
        issued_cnt_next_s = issued_cnt_r;
        if (clear) begin
            state_next_s = S_A_HI;
            op_a_next_s  = {(2*SW_W){1'b0}};
            op_b_next_s  = {(2*SW_W){1'b0}};
        end else begin
            case (state_r)
                S_A_HI: begin
                    if (btn_pulse) begin
                        op_a_next_s[2*SW_W-1:SW_W] = switches;
                        state_next_s               = S_A_LO;
                    end else begin
                        state_next_s = S_A_HI;
                    end
                end
                S_A_LO: begin
                    if (btn_pulse) begin
                        op_a_next_s[SW_W-1:0] = switches;
                        state_next_s          = S_B_HI;
                    end else begin
                        state_next_s = S_A_LO;
                    end
                end
                S_B_HI: begin
                    if (btn_pulse) begin
                        op_b_next_s[2*SW_W-1:SW_W] = switches;
                        state_next_s               = S_B_LO;
                    end else begin
                        state_next_s = S_B_HI;
                    end
                end
                S_B_LO: begin
                    if (btn_pulse) begin
                        op_b_next_s[SW_W-1:0] = switches;
                        state_next_s          = S_ISSUE;
                    end else begin
                        state_next_s = S_B_LO;
                    end
                end
                S_ISSUE: begin
                    // btn_pulse is deliberately ignored while the pair is offered.
                    if (out_ready) begin
                        issued_cnt_next_s = issued_cnt_r + CNT_W'(1);
                        state_next_s      = S_A_HI;
                    end else begin
                        state_next_s = S_ISSUE;
                    end
                end
                default: begin
                    state_next_s = S_A_HI;
                end
            endcase
        end
        // Registered valid tracks the state being entered, so it is high
        // exactly while the state register holds S_ISSUE.
        out_valid_next_s = (state_next_s == S_ISSUE);
    end

    // State and output registers with synchronous reset taking top priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_A_HI;
            op_a_r       <= {(2*SW_W){1'b0}};
            op_b_r       <= {(2*SW_W){1'b0}};
            out_valid_r  <= 1'b0;
            issued_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            op_a_r       <= op_a_next_s;
            op_b_r       <= op_b_next_s;
            out_valid_r  <= out_valid_next_s;
            issued_cnt_r <= issued_cnt_next_s;
        end
    end

    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign out_valid  = out_valid_r;
    assign phase      = state_r;
    assign issued_cnt = issued_cnt_r;

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Directed self-checking bench for operand_entry_sequencer.
module tb_operand_entry_sequencer;

    logic        clock;
    logic        reset;
    logic        btn_pulse;
    logic [15:0] switches;
    logic        clear;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  phase;
    logic [7:0]  issued_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    operand_entry_sequencer #(.SW_W(16), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_pulse  (btn_pulse),
        .switches   (switches),
        .clear      (clear),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .phase      (phase),
        .issued_cnt (issued_cnt)
    );

    // Free-running clock, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One-cycle enter strobe; called and returns at a falling edge.
    task automatic pulse(input logic [15:0] sw);
        btn_pulse = 1'b1;
        switches  = sw;
        @(negedge clock);
        btn_pulse = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_vec({tag, "_phase"}, 64'(phase), 64'd0);
        check_vec({tag, "_op_a"}, 64'(op_a), 64'd0);
        check_vec({tag, "_op_b"}, 64'(op_b), 64'd0);
        check_vec({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_vec({tag, "_cnt"}, 64'(issued_cnt), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        btn_pulse = 1'b0;
        switches  = 16'h0000;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_zero("reset");

        // Basic entry of 1.0 and 2.0.
        pulse(16'h3F80);
        check_vec("a_hi_phase", 64'(phase), 64'd1);
        check_vec("a_hi_valid", 64'(out_valid), 64'd0);
        pulse(16'h0000);
        pulse(16'h4000);
        check_vec("b_hi_phase", 64'(phase), 64'd3);
        pulse(16'h0000);
        check_vec("issue_valid", 64'(out_valid), 64'd1);
        check_vec("issue_phase", 64'(phase), 64'd4);
        check_vec("issue_op_a", 64'(op_a), 64'h3F800000);
        check_vec("issue_op_b", 64'(op_b), 64'h40000000);

        // Stall in S_ISSUE with stray pulses.
        btn_pulse = 1'b1;
        switches  = 16'hFFFF;
        repeat (10) @(negedge clock);
        check_vec("stall_valid", 64'(out_valid), 64'd1);
        check_vec("stall_phase", 64'(phase), 64'd4);
        check_vec("stall_op_a", 64'(op_a), 64'h3F800000);
        check_vec("stall_op_b", 64'(op_b), 64'h40000000);
        // Pulse coincident with ready is ignored.
        out_ready = 1'b1;
        @(negedge clock);
        btn_pulse = 1'b0;
        out_ready = 1'b0;
        check_vec("acc_cnt", 64'(issued_cnt), 64'd1);
        check_vec("acc_phase", 64'(phase), 64'd0);
        check_vec("acc_valid", 64'(out_valid), 64'd0);
        check_vec("acc_op_a_hold", 64'(op_a), 64'h3F800000);

        // Idle hold without pulses.
        repeat (3) @(negedge clock);
        check_vec("idle_phase", 64'(phase), 64'd0);
        check_vec("idle_op_b", 64'(op_b), 64'h40000000);

        // Clear mid-entry, beating a coincident pulse.
        pulse(16'h1234);
        pulse(16'h5678);
        clear     = 1'b1;
        btn_pulse = 1'b1;
        switches  = 16'h9999;
        @(negedge clock);
        clear     = 1'b0;
        btn_pulse = 1'b0;
        check_vec("clr_phase", 64'(phase), 64'd0);
        check_vec("clr_op_a", 64'(op_a), 64'd0);
        check_vec("clr_op_b", 64'(op_b), 64'd0);
        check_vec("clr_cnt", 64'(issued_cnt), 64'd1);
        pulse(16'hAAAA);
        pulse(16'hBBBB);
        pulse(16'hCCCC);
        pulse(16'hDDDD);
        check_vec("fresh_op_a", 64'(op_a), 64'hAAAABBBB);
        check_vec("fresh_op_b", 64'(op_b), 64'hCCCCDDDD);
        check_vec("fresh_valid", 64'(out_valid), 64'd1);
        // Clear in S_ISSUE beats out_ready.
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        clear     = 1'b0;
        out_ready = 1'b0;
        check_vec("clr_iss_cnt", 64'(issued_cnt), 64'd1);
        check_vec("clr_iss_valid", 64'(out_valid), 64'd0);
        check_vec("clr_iss_phase", 64'(phase), 64'd0);

        // Back-to-back pulses.
        pulse(16'h1111);
        pulse(16'h2222);
        pulse(16'h3333);
        check_vec("b2b_valid_pre", 64'(out_valid), 64'd0);
        pulse(16'h4444);
        check_vec("b2b_valid", 64'(out_valid), 64'd1);
        check_vec("b2b_op_a", 64'(op_a), 64'h11112222);
        check_vec("b2b_op_b", 64'(op_b), 64'h33334444);
        accept();
        check_vec("b2b_cnt", 64'(issued_cnt), 64'd2);

        // Reset in S_B_LO, also beating clear.
        pulse(16'h0101);
        pulse(16'h0202);
        pulse(16'h0303);
        check_vec("pre_rst_phase", 64'(phase), 64'd3);
        reset = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear = 1'b0;
        check_zero("rst_blo");

        // Reset in S_ISSUE with out_ready high.
        pulse(16'h0A0A);
        pulse(16'h0B0B);
        pulse(16'h0C0C);
        pulse(16'h0D0D);
        accept();
        pulse(16'h0A0A);
        pulse(16'h0B0B);
        pulse(16'h0C0C);
        pulse(16'h0D0D);
        check_vec("pre_rst_iss", 64'(issued_cnt), 64'd1);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b0;
        check_zero("rst_iss");

        // Counter wrap: 255 transactions then one more.
        for (int i = 0; i < 255; i++) begin
            pulse(16'(i));
            pulse(16'h0001);
            pulse(16'h0002);
            pulse(16'h0003);
            accept();
        end
        check_vec("wrap_255", 64'(issued_cnt), 64'd255);
        pulse(16'h0004);
        pulse(16'h0005);
        pulse(16'h0006);
        pulse(16'h0007);
        accept();
        check_vec("wrap_0", 64'(issued_cnt), 64'd0);
        check_vec("wrap_phase", 64'(phase), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/operand_entry_sequencer.md
OPERAND_ENTRY_SEQUENCER -- requirements
Module: operand_entry_sequencer

Interface
REQ-001 SHALL have parameter: SW_W, 16, width of the switch bank; one half-operand.
REQ-002 SHALL have parameter: CNT_W, 8, width of the issued-pair counter.
REQ-003 SHALL have port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: btn_pulse  input  1  one-cycle "enter" strobe from the upstream button edge-detect stage.
REQ-006 SHALL have port: switches  input  SW_W  half-operand value sampled on btn_pulse.
REQ-007 SHALL have port: clear  input  1  synchronous abort of the current entry.
REQ-008 SHALL have port: op_a  output  2*SW_W  assembled operand A to the FPMAC.
REQ-009 SHALL have port: op_b  output  2*SW_W  assembled operand B to the FPMAC.
REQ-010 SHALL have port: out_valid  output  1  op_a/op_b pair valid for the FPMAC.
REQ-011 SHALL have port: out_ready  input  1  FPMAC accepts the pair.
REQ-012 SHALL have port: phase  output  3  current state encoding, drives status LEDs.
REQ-013 SHALL have port: issued_cnt  output  CNT_W  count of accepted pairs.

Function
REQ-014 SHALL implement states S_A_HI(0), S_A_LO(1), S_B_HI(2), S_B_LO(3), S_ISSUE(4); phase equals the state code.
REQ-015 In S_A_HI with btn_pulse: op_a[2*SW_W-1:SW_W] <= switches, next S_A_LO.
REQ-016 In S_A_LO with btn_pulse: op_a[SW_W-1:0] <= switches, next S_B_HI.
REQ-017 In S_B_HI with btn_pulse: op_b upper half <= switches, next S_B_LO.
REQ-018 In S_B_LO with btn_pulse: op_b lower half <= switches, next S_ISSUE; out_valid rises the following cycle (1-cycle latency from the final pulse).
REQ-019 Without btn_pulse, any S_A_HI..S_B_LO state SHALL hold, with registers unchanged.
REQ-020 In S_ISSUE, out_valid SHALL be 1, and op_a/op_b SHALL remain stable until out_ready is sampled high.
REQ-021 In S_ISSUE with out_ready: issued_cnt increments, next S_A_HI, and out_valid is 0 the next cycle; op_a/op_b hold their last values.
REQ-022 btn_pulse in S_ISSUE SHALL be ignored, including when coincident with out_ready.
REQ-023 Back-to-back btn_pulse on consecutive cycles SHALL each be consumed, one state per cycle.
REQ-024 clear SHALL take priority over btn_pulse and out_ready: next S_A_HI, out_valid 0, op_a/op_b zeroed, issued_cnt unchanged.
REQ-025 issued_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-026 out_valid SHALL be a registered output equal to (state == S_ISSUE).

Reset
REQ-027 On reset, state SHALL be S_A_HI, op_a=0, op_b=0, out_valid=0, issued_cnt=0, and phase=0.
REQ-028 Reset SHALL take priority over clear and all other inputs, including mid-entry and during S_ISSUE.

Structure
REQ-029 A shared package SHALL hold the state enum, the phase codes, and the SW_W/CNT_W defaults.
REQ-030 There SHALL be a single module with no sub-module; edge detection stays in the upstream stage.

Verification
REQ-031 Reset, then pulses with switches 0x3F80, 0x0000, 0x4000, 0x0000 -> op_a=0x3F800000, op_b=0x40000000, and out_valid=1 one cycle after the 4th pulse.
REQ-032 Hold out_ready=0 for 10 cycles in S_ISSUE with extra pulses (switches 0xFFFF) -> out_valid stays 1 and the operands are unchanged; out_ready=1 -> issued_cnt=1, phase=0.
REQ-033 Two pulses, then clear -> phase=0, op_a=0, issued_cnt unchanged; the next four pulses load fresh operands.
REQ-034 255 full transactions plus 1 -> issued_cnt wraps to 0.
REQ-035 Four pulses on consecutive cycles (0x1111, 0x2222, 0x3333, 0x4444) -> op_a=0x11112222, op_b=0x33334444, and out_valid on cycle 5.
REQ-036 reset asserted in S_B_LO and in S_ISSUE -> all outputs return to zero on the next edge.
